// File: rtl/win_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Tap k = ky*3 + kx, with ky=0 the top row and kx=0 the left column.
package win_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } win_state_e;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  localparam int DEF_DW = 32;
  localparam int DEF_W  = 56;
  localparam int DEF_H  = 56;

endpackage

// File: rtl/row_tap_sel.sv
// Picks the left/centre/right pixels around col from one row.
// Columns -1 and W read as zero through a padded copy of the row.
module row_tap_sel #(
  parameter int DW = 32,
  parameter int W  = 56,
  parameter int CW = $clog2(W)
) (
  input  logic [DW*W-1:0] row,
  input  logic [CW-1:0]   col,
  output logic [DW-1:0]   left,
  output logic [DW-1:0]   centre,
  output logic [DW-1:0]   right
);

  logic [DW*(W+2)-1:0] padded;

  // Pixel 0 sits in the MSBs, so padded pixel index q = p+1 lives at (W+1-q)*DW.
  assign padded = {{DW{1'b0}}, row, {DW{1'b0}}};

  always_comb begin
    left   = '0;
    centre = '0;
    right  = '0;
    if (int'(col) < W) begin
      left   = padded[(W + 1 - int'(col))*DW +: DW];
      centre = padded[(W - int'(col))*DW     +: DW];
      right  = padded[(W - 1 - int'(col))*DW +: DW];
    end
  end

endmodule

// File: rtl/win3x3_gen.sv
// Three-row sliding window producing zero-padded 3x3 windows (pad=1, stride=1)
// with a valid/ready output; exactly H*W windows per frame.
//
// state | meaning
// IDLE  | waiting for start; row buffers idle
// LOAD  | row_ready high; shifting rows in until need reaches 0
// EMIT  | win_valid high; walking col across the current output row
// DONE  | one-cycle frame_done pulse, then back to IDLE
module win3x3_gen
  import win_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int W  = DEF_W,
  parameter int H  = DEF_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DW*W-1:0]      row_i,
  input  logic                 row_valid,
  output logic                 row_ready,
  output logic [9*DW-1:0]      win_o,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [$clog2(H)-1:0] win_row,
  output logic [$clog2(W)-1:0] win_col,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  win_state_e      state_q, state_d;
  logic [DW*W-1:0] top_q, mid_q, bot_q;
  logic [DW*W-1:0] top_d, mid_d, bot_d;
  logic [1:0]      need_q, need_d;
  logic [RW-1:0]   out_r_q, out_r_d;
  logic [CW-1:0]   col_q, col_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      need_q  <= '0;
      out_r_q <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      need_q  <= need_d;
      out_r_q <= out_r_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    mid_d      = mid_q;
    bot_d      = bot_q;
    need_d     = need_q;
    out_r_d    = out_r_q;
    col_d      = col_q;
    row_ready  = 1'b0;
    win_valid  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          top_d   = '0;
          mid_d   = '0;
          bot_d   = '0;
          out_r_d = '0;
          col_d   = '0;
          need_d  = 2'd2;
          state_d = LOAD;
        end
      end
      LOAD: begin
        row_ready = 1'b1;
        if (row_valid) begin
          top_d  = mid_q;
          mid_d  = bot_q;
          bot_d  = row_i;
          need_d = need_q - 2'd1;
          if (need_q == 2'd1) begin
            col_d   = '0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        win_valid = 1'b1;
        if (win_ready) begin
          if (col_q == CW'(W - 1)) begin
            col_d = '0;
            if (out_r_q == RW'(H - 1)) begin
              state_d = DONE;
            end else if (out_r_q < RW'(H - 2)) begin
              out_r_d = out_r_q + RW'(1);
              need_d  = 2'd1;
              state_d = LOAD;
            end else begin
              // Last output row: no more input, shift in a zero bottom pad.
              out_r_d = out_r_q + RW'(1);
              top_d   = mid_q;
              mid_d   = bot_q;
              bot_d   = '0;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DW-1:0] tl, tc, tr, ml, mc, mr, bl, bc, br;

  row_tap_sel #(.DW(DW), .W(W), .CW(CW)) u_sel_top (
    .row(top_q), .col(col_q), .left(tl), .centre(tc), .right(tr)
  );
  row_tap_sel #(.DW(DW), .W(W), .CW(CW)) u_sel_mid (
    .row(mid_q), .col(col_q), .left(ml), .centre(mc), .right(mr)
  );
  row_tap_sel #(.DW(DW), .W(W), .CW(CW)) u_sel_bot (
    .row(bot_q), .col(col_q), .left(bl), .centre(bc), .right(br)
  );

  always_comb begin
    win_o = '0;
    if (win_valid) begin
      win_o[TAP_TL*DW +: DW] = tl;
      win_o[TAP_TC*DW +: DW] = tc;
      win_o[TAP_TR*DW +: DW] = tr;
      win_o[TAP_ML*DW +: DW] = ml;
      win_o[TAP_MC*DW +: DW] = mc;
      win_o[TAP_MR*DW +: DW] = mr;
      win_o[TAP_BL*DW +: DW] = bl;
      win_o[TAP_BC*DW +: DW] = bc;
      win_o[TAP_BR*DW +: DW] = br;
    end
  end

  assign win_row = out_r_q;
  assign win_col = col_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_win3x3_gen.sv
// Bench for win3x3_gen: frames of patterned or random pixels, with windows
// compared against a padded-image reference computed directly from the pixel array.
module tb_win3x3_gen;

  localparam int DW = 32;
  localparam int W  = 56;
  localparam int H  = 56;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DW*W-1:0]   row_i;
  logic              row_valid;
  logic              row_ready;
  logic [9*DW-1:0]   win_o;
  logic              win_valid;
  logic              win_ready;
  logic [RW-1:0]     win_row;
  logic [CW-1:0]     win_col;
  logic              busy;
  logic              frame_done;

  win3x3_gen #(.DW(DW), .W(W), .H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row_i(row_i), .row_valid(row_valid), .row_ready(row_ready),
    .win_o(win_o), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] pix [H][W];

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pad_pix(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return '0;
    return pix[r][c];
  endfunction

  function automatic logic [9*DW-1:0] exp_win(int r, int c);
    logic [9*DW-1:0] v = '0;
    for (int k = 0; k < 9; k++)
      v[k*DW +: DW] = pad_pix(r + k/3 - 1, c + k%3 - 1);
    return v;
  endfunction

  function automatic logic [DW*W-1:0] pack_row(int r);
    logic [DW*W-1:0] v = '0;
    for (int p = 0; p < W; p++) v[(W-1-p)*DW +: DW] = pix[r][p];
    return v;
  endfunction

  task automatic fill_frame(input bit pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = pattern ? DW'(r*256 + c) : DW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_row_ready"}, row_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_win_o"}, win_o, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
  endtask

  task automatic run_frame(input bit pattern, input int ready_pct, input bit hold_valid,
                           input bit poke_start, input int abort_idx);
    int  er = 0, ec = 0, rows_sent = 0, budget = 20000, rows_cap;
    bit  expect_done = 0, prev_done = 0, finished = 0, aborted = 0;
    fill_frame(pattern);
    @(negedge clk);
    chk("pre_start_busy", busy, 0);
    start = 1'b1;
    while (!finished && budget > 0) begin
      @(negedge clk);
      budget--;
      start = 1'b0;
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_single_pulse", frame_done, 0);
        finished = 1;
        break;
      end
      chk("frame_done", frame_done, expect_done);
      if (expect_done) begin
        chk("busy_in_done", busy, 1);
        chk("no_win_in_done", win_valid, 0);
        chk("no_row_in_done", row_ready, 0);
        prev_done   = 1;
        expect_done = 0;
        row_valid   = 1'b0;
        win_ready   = 1'b0;
        continue;
      end
      if (win_valid) begin
        if (abort_idx == er*W + ec) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("abort");
          @(negedge clk);
          rst_n     = 1'b1;
          row_valid = 1'b0;
          win_ready = 1'b0;
          aborted   = 1;
          break;
        end
        rows_cap = (er + 2 < H) ? er + 2 : H;
        chk("win_row", win_row, er);
        chk("win_col", win_col, ec);
        chk("win_data", win_o, exp_win(er, ec));
        chk("rows_at_emit", rows_sent, rows_cap);
        chk("row_ready_in_emit", row_ready, 0);
        if (er == 0) chk("top_pad", win_o[3*DW-1:0], 0);
        if (er == H-1) chk("bottom_pad", win_o[9*DW-1:6*DW], 0);
        if (pattern && er == 0 && ec == 0) begin
          chk("w00_tap0_3", win_o[4*DW-1:0], 0);
          chk("w00_tap4", win_o[4*DW +: DW], 32'h000);
          chk("w00_tap5", win_o[5*DW +: DW], 32'h001);
          chk("w00_tap6", win_o[6*DW +: DW], 0);
          chk("w00_tap7", win_o[7*DW +: DW], 32'h100);
          chk("w00_tap8", win_o[8*DW +: DW], 32'h101);
        end
        if (pattern && er == 10 && ec == 20) begin
          chk("w1020_tap0", win_o[0*DW +: DW], 32'h913);
          chk("w1020_tap4", win_o[4*DW +: DW], 32'hA14);
          chk("w1020_tap8", win_o[8*DW +: DW], 32'hB15);
        end
      end
      win_ready = ($urandom_range(99) < ready_pct);
      row_valid = hold_valid ? 1'b1 : 1'($urandom_range(1));
      row_i     = pack_row(rows_sent < H ? rows_sent : 0);
      if (poke_start && win_valid && $urandom_range(3) == 0) start = 1'b1;
      if (row_valid && row_ready) begin
        rows_cap = (er + 2 < H) ? er + 2 : H;
        chk("row_accept_allowed", rows_sent < rows_cap, 1);
        rows_sent++;
      end
      if (win_valid && win_ready) begin
        if (ec == W-1) begin
          ec = 0;
          if (er == H-1) expect_done = 1;
          else er++;
        end else begin
          ec++;
        end
      end
    end
    row_valid = 1'b0;
    win_ready = 1'b0;
    start     = 1'b0;
    if (!aborted) begin
      chk("frame_within_budget", finished, 1);
      chk("rows_per_frame", rows_sent, H);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    row_i     = '0;
    row_valid = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_frame(1'b1, 100, 1'b0, 1'b0, -1);
    run_frame(1'b0, 50,  1'b0, 1'b0, -1);
    run_frame(1'b1, 70,  1'b1, 1'b1, -1);
    run_frame(1'b0, 40,  1'b1, 1'b0, -1);
    run_frame(1'b1, 100, 1'b0, 1'b0, 10*W + 20);
    run_frame(1'b1, 100, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
